dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_align.sv | 63 ++++++
 rtl/dmem_responder.sv | 145 ++++++++++++++
 tb/tb_dmem_responder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_pkg : access-size codes and FSM state encoding for dmem_responder   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package dmem_pkg;

   // funct3 load/store size codes
   localparam logic [2:0] SZ_B  = 3'b000;
   localparam logic [2:0] SZ_H  = 3'b001;
   localparam logic [2:0] SZ_W  = 3'b010;
   localparam logic [2:0] SZ_BU = 3'b100;
   localparam logic [2:0] SZ_HU = 3'b101;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_WAIT = 2'd1;
   localparam state_t ST_RESP = 2'd2;

endpackage
`default_nettype wire

// File: rtl/dmem_align.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_align : byte-lane enables, load extension and access error check    |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
module dmem_align
   import dmem_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  write,
   input  logic [2:0]            size,
   input  logic [1:0]            addr_lo,
   input  logic [31:0]           wdata,
   input  logic [31:0]           rword,      // lane 0 is the addressed byte
   output logic [3:0]            byte_en,
   output logic [31:0]           wbytes,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  err
);

   always_comb begin
      err = 1'b0;
      case (size)
         SZ_B:    err = 1'b0;
         SZ_H:    err = addr_lo[0];
         SZ_W:    err = (addr_lo != 2'b00);
         SZ_BU:   err = write;
         SZ_HU:   err = write | addr_lo[0];
         default: err = 1'b1;
      endcase
   end

   always_comb begin
      byte_en = 4'b0000;
      if (write && !err) begin
         case (size)
            SZ_B:    byte_en = 4'b0001;
            SZ_H:    byte_en = 4'b0011;
            SZ_W:    byte_en = 4'b1111;
            default: byte_en = 4'b0000;
         endcase
      end
   end

   assign wbytes = wdata;

   always_comb begin
      rdata = '0;
      if (!write && !err) begin
         case (size)
            SZ_B:    rdata = DATA_WIDTH'($signed(rword[7:0]));
            SZ_H:    rdata = DATA_WIDTH'($signed(rword[15:0]));
            SZ_W:    rdata = DATA_WIDTH'(rword);
            SZ_BU:   rdata = DATA_WIDTH'(rword[7:0]);
            SZ_HU:   rdata = DATA_WIDTH'(rword[15:0]);
            default: rdata = '0;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_responder : byte-addressed data memory with fixed response latency |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 17,
   parameter int LATENCY    = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [2:0]            req_size,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  busy
);

   localparam int MEM_BYTES = 1 << ADDR_WIDTH;

   logic [7:0]            r_mem [MEM_BYTES];
   state_t                r_state;
   logic [3:0]            r_count;
   logic                  r_write;
   logic [2:0]            r_size;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_rsp_rdata;
   logic                  r_rsp_err;

   logic                  w_accept;
   logic                  w_enter_resp;
   logic                  w_sel_in;
   logic                  w_write;
   logic [2:0]            w_size;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [DATA_WIDTH-1:0] w_wdata;
   logic [ADDR_WIDTH-1:0] w_lane_addr [4];
   logic [31:0]           w_rword;
   logic [3:0]            w_byte_en;
   logic [31:0]           w_wbytes;
   logic [DATA_WIDTH-1:0] w_rdata;
   logic                  w_err;

   assign w_accept     = rst && (r_state == ST_IDLE) && req_valid;
   assign w_enter_resp = (w_accept && (LATENCY == 1)) ||
                         ((r_state == ST_WAIT) && (r_count == 4'd1));

   // With LATENCY 1 the commit edge is the accept edge, so the live request is used
   assign w_sel_in = (r_state == ST_IDLE);
   assign w_write  = w_sel_in ? req_write : r_write;
   assign w_size   = w_sel_in ? req_size  : r_size;
   assign w_addr   = w_sel_in ? req_addr  : r_addr;
   assign w_wdata  = w_sel_in ? req_wdata : r_wdata;

   for (genvar i = 0; i < 4; i++) begin : g_lane
      assign w_lane_addr[i]    = w_addr + ADDR_WIDTH'(i);
      assign w_rword[8*i +: 8] = r_mem[w_lane_addr[i]];
   end

   dmem_align #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_align (
      .write   (w_write),
      .size    (w_size),
      .addr_lo (w_addr[1:0]),
      .wdata   (w_wdata[31:0]),
      .rword   (w_rword),
      .byte_en (w_byte_en),
      .wbytes  (w_wbytes),
      .rdata   (w_rdata),
      .err     (w_err)
   );

   // Array is deliberately outside the reset domain so contents survive reset
   always_ff @(posedge clk) begin
      if (w_enter_resp) begin
         for (int i = 0; i < 4; i++) begin
            if (w_byte_en[i]) begin
               r_mem[w_lane_addr[i]] <= w_wbytes[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_count     <= 4'd0;
         r_write     <= 1'b0;
         r_size      <= 3'b000;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
         if (w_enter_resp) begin
            r_rsp_rdata <= w_rdata;
            r_rsp_err   <= w_err;
         end
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_write <= req_write;
                  r_size  <= req_size;
                  r_addr  <= req_addr;
                  r_wdata <= req_wdata;
                  if (LATENCY == 1) begin
                     r_state <= ST_RESP;
                  end else begin
                     r_state <= ST_WAIT;
                     r_count <= 4'(LATENCY - 1);
                  end
               end
            end
            ST_WAIT: begin
               r_count <= r_count - 4'd1;
               if (r_count == 4'd1) begin
                  r_state <= ST_RESP;
               end
            end
            ST_RESP: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign req_ready = (r_state == ST_IDLE);
   assign busy      = (r_state != ST_IDLE);
   assign rsp_valid = (r_state == ST_RESP);
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dmem_responder : scoreboard bench for dmem_responder (LATENCY 3 and 1)|
// | Revision          : 1.0                                                  |
// +--------------------------------------------------------------------------+
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   always #5 clk = ~clk;

   logic        req_valid = 1'b0, req_write = 1'b0;
   logic [2:0]  req_size = 3'b000;
   logic [16:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        req_ready, rsp_valid, rsp_err, busy;
   logic [31:0] rsp_rdata;

   logic        req_valid1 = 1'b0, req_write1 = 1'b0;
   logic [2:0]  req_size1 = 3'b000;
   logic [7:0]  req_addr1 = '0;
   logic [31:0] req_wdata1 = '0;
   logic        req_ready1, rsp_valid1, rsp_err1, busy1;
   logic [31:0] rsp_rdata1;

   dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(17), .LATENCY(3)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_size(req_size), .req_addr(req_addr),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .busy(busy)
   );

   dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .LATENCY(1)) dut1 (
      .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1),
      .req_write(req_write1), .req_size(req_size1), .req_addr(req_addr1),
      .req_wdata(req_wdata1), .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1),
      .rsp_err(rsp_err1), .busy(busy1)
   );

   typedef struct {
      int          cyc;
      logic [31:0] d;
      logic        e;
   } exp_t;

   exp_t q[$];
   exp_t m_e;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: every response is matched against the oldest expectation
   always @(negedge clk) begin
      if (rsp_valid) begin
         if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rsp actual=rdata %h err %b required=no response", rsp_rdata, rsp_err);
         end else begin
            m_e = q.pop_front();
            chk("rsp_cycle", cyc, m_e.cyc);
            chk("rsp_rdata", rsp_rdata, m_e.d);
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, m_e.e});
         end
      end else begin
         chk("idle_rdata", rsp_rdata, 32'd0);
         chk("idle_err", {31'd0, rsp_err}, 32'd0);
      end
   end

   task automatic issue(input logic w, input logic [2:0] sz, input logic [16:0] a,
                        input logic [31:0] wd, input logic [31:0] er, input logic ee);
      int n = 0;
      @(negedge clk);
      req_valid = 1'b1; req_write = w; req_size = sz; req_addr = a; req_wdata = wd;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout actual=not ready required=ready");
      end else begin
         q.push_back('{cyc + 3, er, ee});
      end
      @(posedge clk);
      #1;
      // Scramble the bus after acceptance; the captured request must be used
      req_valid = 1'b0; req_write = ~w; req_size = 3'b010; req_addr = ~a; req_wdata = ~wd;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout actual=%0d pending required=0", q.size());
         q.delete();
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int start;
      #2 rst = 1'b0;
      #1;
      chk("rst_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rdata", rsp_rdata, 32'd0);
      chk("rst_err", {31'd0, rsp_err}, 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b1;

      issue(1'b1, 3'b010, 17'h100, 32'hDEADBEEF, 32'h0, 1'b0);
      issue(1'b0, 3'b010, 17'h100, 32'h0, 32'hDEADBEEF, 1'b0);
      issue(1'b0, 3'b000, 17'h103, 32'h0, 32'hFFFFFFDE, 1'b0);
      issue(1'b0, 3'b100, 17'h103, 32'h0, 32'h000000DE, 1'b0);
      issue(1'b0, 3'b001, 17'h100, 32'h0, 32'hFFFFBEEF, 1'b0);
      issue(1'b0, 3'b101, 17'h102, 32'h0, 32'h0000DEAD, 1'b0);
      issue(1'b1, 3'b000, 17'h101, 32'h00000012, 32'h0, 1'b0);
      issue(1'b0, 3'b010, 17'h100, 32'h0, 32'hDEAD12EF, 1'b0);
      issue(1'b1, 3'b001, 17'h101, 32'h0000AAAA, 32'h0, 1'b1);
      issue(1'b0, 3'b010, 17'h100, 32'h0, 32'hDEAD12EF, 1'b0);
      issue(1'b0, 3'b010, 17'h102, 32'h0, 32'h0, 1'b1);
      issue(1'b0, 3'b011, 17'h100, 32'h0, 32'h0, 1'b1);
      issue(1'b1, 3'b100, 17'h100, 32'h00000077, 32'h0, 1'b1);
      issue(1'b0, 3'b010, 17'h100, 32'h0, 32'hDEAD12EF, 1'b0);
      issue(1'b1, 3'b010, 17'h1FFFC, 32'hCAFEF00D, 32'h0, 1'b0);
      issue(1'b0, 3'b010, 17'h1FFFC, 32'h0, 32'hCAFEF00D, 1'b0);
      issue(1'b0, 3'b001, 17'h1FFFE, 32'h0, 32'hFFFFCAFE, 1'b0);
      issue(1'b0, 3'b010, 17'h1FFFD, 32'h0, 32'h0, 1'b1);
      drain();

      // Request held high: accepts in cycles 0 and 4 of the window
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_size = 3'b010; req_addr = 17'h100;
      start = cyc;
      q.push_back('{start + 3, 32'hDEAD12EF, 1'b0});
      q.push_back('{start + 7, 32'hDEAD12EF, 1'b0});
      for (int i = 0; i < 8; i++) begin
         chk("hold_ready", {31'd0, req_ready}, {31'd0, (i % 4 == 0)});
         chk("hold_busy", {31'd0, busy}, {31'd0, (i % 4 != 0)});
         @(negedge clk);
      end
      req_valid = 1'b0;
      drain();

      // Reset during WAIT must discard a pending store
      issue(1'b1, 3'b010, 17'h200, 32'h11223344, 32'h0, 1'b0);
      drain();
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_size = 3'b010; req_addr = 17'h200; req_wdata = 32'h55;
      chk("abort_accept_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("abort_ready", {31'd0, req_ready}, 32'd1);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_valid", {31'd0, rsp_valid}, 32'd0);
      chk("abort_rdata", rsp_rdata, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      issue(1'b0, 3'b010, 17'h200, 32'h0, 32'h11223344, 1'b0);
      drain();

      // LATENCY 1 instance
      @(negedge clk);
      req_valid1 = 1'b1; req_write1 = 1'b1; req_size1 = 3'b010; req_addr1 = 8'h10; req_wdata1 = 32'h0BADF00D;
      @(posedge clk);
      #1 req_valid1 = 1'b0;
      @(negedge clk);
      chk("l1_sw_valid", {31'd0, rsp_valid1}, 32'd1);
      chk("l1_sw_err", {31'd0, rsp_err1}, 32'd0);
      @(negedge clk);
      req_valid1 = 1'b1; req_write1 = 1'b0; req_size1 = 3'b010; req_addr1 = 8'h10;
      chk("l1_c0_ready", {31'd0, req_ready1}, 32'd1);
      @(posedge clk);
      #1 req_valid1 = 1'b0; req_addr1 = 8'h00;
      @(negedge clk);
      chk("l1_c1_valid", {31'd0, rsp_valid1}, 32'd1);
      chk("l1_c1_rdata", rsp_rdata1, 32'h0BADF00D);
      chk("l1_c1_ready", {31'd0, req_ready1}, 32'd0);
      @(negedge clk);
      chk("l1_c2_ready", {31'd0, req_ready1}, 32'd1);
      chk("l1_c2_valid", {31'd0, rsp_valid1}, 32'd0);
      chk("l1_c2_rdata", rsp_rdata1, 32'd0);

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
